lsu: RTL
========

Name: lsu

Overview:
Load/store unit directly upstream of the byte-masked data RAM (two read ports, one write port, 64-bit words, byte-address inputs with the low 3 bits ignored). It accepts one RISC-V load/store request at a time from the execute stage and generates the RAM byte masks. Misaligned accesses that cross a 64-bit word boundary are split into two RAM accesses. For loads it performs byte-lane alignment and sign or zero extension, then returns the result over a valid/ready response channel.

Parameters:
DATA_WIDTH, 64, RAM word width; fixed at 64. Other values are unsupported.
ADDR_WIDTH, 10, byte-address width; must match the RAM.
MASK_WIDTH, DATA_WIDTH>>3, byte-lane count (8).

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid&ready
i_req_we  in  1  1=store, 0=load
i_req_funct3  in  3  RISC-V funct3 (size[1:0], unsigned[2])
i_req_addr  in  ADDR_WIDTH  byte address
i_req_wdata  in  DATA_WIDTH  store data, LSB-aligned
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores
o_rsp_err  out  1  illegal funct3; no RAM access performed
o_rd_addr  out  ADDR_WIDTH  to RAM rd1 addr, always {word,3'b000}
o_rd_en  out  1  to RAM rd1 enable
o_rd_mask  out  MASK_WIDTH  to RAM rd1 byte mask
i_rd_data  in  DATA_WIDTH  from RAM rd1 data (combinational)
o_wr_addr  out  ADDR_WIDTH  to RAM wr addr
o_wr_en  out  1  to RAM wr enable
o_wr_mask  out  MASK_WIDTH  to RAM wr byte mask
o_wr_data  out  DATA_WIDTH  to RAM wr data, lane-shifted

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rd_en, o_wr_en and all masks/addr/data outputs are 0.
  - o_req_ready=1.
  - Reset mid-operation aborts it immediately: no further RAM write is issued, and no response is produced for the aborted request.
- States: IDLE, ACC0, ACC1, RESP. o_req_ready = (state==IDLE).
- IDLE, on valid&ready:
  - Register we, funct3, addr, wdata.
  - Compute n = 1<<funct3[1:0], off = addr[2:0], split = (off+n>8).
  - Illegal funct3 (load funct3==3'b111, or store with funct3[2]=1): set err, go to RESP with no RAM access.
  - Otherwise go to ACC0.
- ACC0:
  - RAM address is word w = addr[ADDR_WIDTH-1:3].
  - mask0 = (((1<<n)-1)<<off)[7:0].
  - Load: o_rd_en=1 with mask0; capture i_rd_data>>(8*off) into the data register.
  - Store: o_wr_en=1 with mask0; o_wr_data = wdata<<(8*off).
  - Next state is ACC1 if split, else RESP.
- ACC1:
  - RAM address is word w+1, modulo 2^(ADDR_WIDTH-3) (wraps to word 0 at top of memory).
  - mask1 = ((1<<n)-1)>>(8-off).
  - Load: OR i_rd_data<<(8*(8-off)) into the data register.
  - Store: o_wr_data = wdata>>(8*(8-off)).
  - Next state is RESP.
- RESP:
  - o_rsp_valid=1. o_rsp_rdata and o_rsp_err are held stable until i_rsp_ready.
  - On handshake, go to IDLE. The next request can be accepted the cycle after the handshake.
- Load extension on the low n bytes:
  - funct3 000/001/010: sign-extend from bit 8n-1.
  - 011: pass-through.
  - 100/101/110: zero-extend.
- RAM control outputs are combinational from state and registered request. o_rd_en/o_wr_en are 0 outside ACC0/ACC1. Masks are 0 whenever the corresponding enable is 0.
- Latency from accept to o_rsp_valid:
  - Non-split: 2 cycles.
  - Split: 3 cycles.
  - Error: 1 cycle.
- Each request issues at most one RAM write per word, and a store's write completes before its response.

Test Plan:
- RAM word0=0x8877665544332211, LB addr 0x007 -> rdata=0xFFFFFFFFFFFFFF88, err=0, rsp_valid 2 cycles after accept, rd_mask=0x80.
- LHU addr 0x002 on the same RAM -> rdata=0x0000000000004433, rd_mask=0x0C, single access.
- SW addr 0x006, wdata=0xDEADBEEF -> ACC0 wr_mask=0xC0, data lanes 6-7=0xBEEF at word0; ACC1 wr_mask=0x03, 0xDEAD at word1; rsp 3 cycles after accept. LW readback of addr 0x006 returns 0xFFFFFFFFDEADBEEF.
- LD addr 0x3FC (ADDR_WIDTH=10) -> second access at word 0 (o_rd_addr=0x000); rdata = lanes 4-7 of word 127 combined with lanes 0-3 of word 0.
- Load funct3=3'b111 -> err=1, rdata=0, rd_en and wr_en never asserted, rsp 1 cycle after accept. Hold i_rsp_ready=0 for 5 cycles -> rsp_valid stays 1, o_req_ready stays 0.
- Split store with i_rst_n pulled low during ACC0 -> o_wr_en drops the same cycle, word1 is unmodified, and o_req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu.sv
// lsu: RISC-V load/store unit in front of a 64-bit byte-masked data RAM.
// Word-crossing accesses are split in two; load data is lane-aligned and extended.
`default_nettype none

module lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int MASK_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_en,
  output logic [MASK_WIDTH-1:0] o_rd_mask,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_wr_en,
  output logic [MASK_WIDTH-1:0] o_wr_mask,
  output logic [DATA_WIDTH-1:0] o_wr_data
);

  localparam int WORD_W = ADDR_WIDTH - 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [2:0]            w_off;
  logic [3:0]            w_nbytes;
  logic [MASK_WIDTH-1:0] w_ones;
  logic [MASK_WIDTH-1:0] w_mask0;
  logic [MASK_WIDTH-1:0] w_mask1;
  logic                  w_split;
  logic [5:0]            w_sh0;
  logic [5:0]            w_sh1;
  logic [WORD_W-1:0]     w_word0;
  logic [WORD_W-1:0]     w_word1;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_off    = addr_q[2:0];
  assign w_nbytes = 4'd1 << funct3_q[1:0];
  assign w_ones   = 8'hFF >> (4'd8 - w_nbytes);
  assign w_mask0  = w_ones << w_off;
  // Second-access lanes are the bytes that spilled past lane 7 of the first word.
  assign w_mask1  = w_ones >> (4'd8 - {1'b0, w_off});
  assign w_split  = ({1'b0, w_off} + w_nbytes) > 4'd8;
  assign w_sh0    = {w_off, 3'b000};
  assign w_sh1    = 6'(7'd64 - {1'b0, w_off, 3'b000});
  assign w_word0  = addr_q[ADDR_WIDTH-1:3];
  assign w_word1  = w_word0 + {{(WORD_W-1){1'b0}}, 1'b1};

  assign w_illegal = i_req_we ? i_req_funct3[2] : (i_req_funct3 == 3'b111);

  always_comb begin
    w_ext = '0;
    case (funct3_q)
      3'b000:  w_ext = {{56{data_q[7]}},  data_q[7:0]};
      3'b001:  w_ext = {{48{data_q[15]}}, data_q[15:0]};
      3'b010:  w_ext = {{32{data_q[31]}}, data_q[31:0]};
      3'b011:  w_ext = data_q;
      3'b100:  w_ext = {56'd0, data_q[7:0]};
      3'b101:  w_ext = {48'd0, data_q[15:0]};
      3'b110:  w_ext = {32'd0, data_q[31:0]};
      default: w_ext = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    err_d       = err_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_rdata = '0;
    o_rsp_err   = 1'b0;
    o_rd_addr   = '0;
    o_rd_en     = 1'b0;
    o_rd_mask   = '0;
    o_wr_addr   = '0;
    o_wr_en     = 1'b0;
    o_wr_mask   = '0;
    o_wr_data   = '0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          we_d     = i_req_we;
          funct3_d = i_req_funct3;
          addr_d   = i_req_addr;
          wdata_d  = i_req_wdata;
          data_d   = '0;
          err_d    = w_illegal;
          state_d  = w_illegal ? RESP : ACC0;
        end
      end
      ACC0: begin
        if (we_q) begin
          o_wr_en   = 1'b1;
          o_wr_addr = {w_word0, 3'b000};
          o_wr_mask = w_mask0;
          o_wr_data = wdata_q << w_sh0;
        end else begin
          o_rd_en   = 1'b1;
          o_rd_addr = {w_word0, 3'b000};
          o_rd_mask = w_mask0;
          data_d    = i_rd_data >> w_sh0;
        end
        state_d = w_split ? ACC1 : RESP;
      end
      ACC1: begin
        if (we_q) begin
          o_wr_en   = 1'b1;
          o_wr_addr = {w_word1, 3'b000};
          o_wr_mask = w_mask1;
          o_wr_data = wdata_q >> w_sh1;
        end else begin
          o_rd_en   = 1'b1;
          o_rd_addr = {w_word1, 3'b000};
          o_rd_mask = w_mask1;
          data_d    = data_q | (i_rd_data << w_sh1);
        end
        state_d = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (we_q || err_q) ? '0 : w_ext;
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

endmodule

`default_nettype wire
